// File: rtl/filtro_iir_multicanal.sv
// Multichannel biquad IIR (direct form I) with one shared multiplier.
// Ports: Clk/Reset_n, Uk/Canal/Bandera_ADC sample in, Bypass,
//   Coef_We/Coef_Sel/Coef_Canal/Coef_Dato coefficient load,
//   Yk/Canal_Yk/Bandera_Listo result, Ocupado, Bandera_Saturacion,
//   Bandera_Perdida dropped-sample pulse.
module filtro_iir_multicanal #(
    parameter int N  = 25,
    parameter int F  = 15,
    parameter int C  = 2,
    parameter int CW = 1
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic signed [N-1:0] Uk,
    input  logic [CW-1:0]       Canal,
    input  logic                Bandera_ADC,
    input  logic                Bypass,
    input  logic                Coef_We,
    input  logic [2:0]          Coef_Sel,
    input  logic [CW-1:0]       Coef_Canal,
    input  logic signed [N-1:0] Coef_Dato,
    output logic signed [N-1:0] Yk,
    output logic [CW-1:0]       Canal_Yk,
    output logic                Bandera_Listo,
    output logic                Ocupado,
    output logic                Bandera_Saturacion,
    output logic                Bandera_Perdida
);

    localparam int AW = 2*N + 3;
    localparam logic [CW:0]          C_L  = (CW+1)'(C);
    localparam logic signed [N-1:0]  UNO  = N'(2**F);
    localparam logic signed [AW-1:0] RND  = AW'(2**(F-1));
    localparam logic signed [AW-1:0] MAXV = AW'(2**(N-1) - 1);
    localparam logic signed [AW-1:0] MINV = ~MAXV;

    typedef enum logic [1:0] {REPOSO, MAC, REDONDEO} estado_t;

    estado_t estado;
    logic [2:0] k;

    // coef[ch][0..4] = b0, b1, b2, a1, a2
    logic signed [N-1:0] coef [C][5];
    logic signed [N-1:0] hx1 [C];
    logic signed [N-1:0] hx2 [C];
    logic signed [N-1:0] hy1 [C];
    logic signed [N-1:0] hy2 [C];

    logic signed [N-1:0]  x_r;
    logic [CW-1:0]        canal_r;
    logic                 bypass_r;
    logic signed [AW-1:0] acc;

    logic signed [N-1:0]   op_c;
    logic signed [N-1:0]   op_x;
    logic signed [2*N-1:0] prod;
    logic signed [AW-1:0]  prod_ext;
    logic signed [AW-1:0]  acc_nxt;
    logic signed [AW-1:0]  red;
    logic signed [N-1:0]   res_val;
    logic                  res_sat;
    logic                  coef_ok;

    // Operand select for the single shared multiplier
    always_comb begin
        op_c = '0;
        op_x = '0;
        unique case (k)
            3'd0: begin op_c = coef[canal_r][0]; op_x = x_r;          end
            3'd1: begin op_c = coef[canal_r][1]; op_x = hx1[canal_r]; end
            3'd2: begin op_c = coef[canal_r][2]; op_x = hx2[canal_r]; end
            3'd3: begin op_c = coef[canal_r][3]; op_x = hy1[canal_r]; end
            3'd4: begin op_c = coef[canal_r][4]; op_x = hy2[canal_r]; end
            default: ;
        endcase
    end

    assign prod     = op_c * op_x;
    assign prod_ext = {{3{prod[2*N-1]}}, prod};
    // Feedback terms (a1, a2) are subtracted
    assign acc_nxt  = (k >= 3'd3) ? acc - prod_ext : acc + prod_ext;
    // Round half up, then arithmetic shift
    assign red      = (acc + RND) >>> F;

    always_comb begin
        res_val = red[N-1:0];
        res_sat = 1'b0;
        if (red > MAXV) begin
            res_val = {1'b0, {(N-1){1'b1}}};
            res_sat = 1'b1;
        end else if (red < MINV) begin
            res_val = {1'b1, {(N-1){1'b0}}};
            res_sat = 1'b1;
        end
        if (bypass_r) begin
            res_val = x_r;
            res_sat = 1'b0;
        end
    end

    // A busy channel's coefficients are frozen so a result never mixes old/new sets
    assign coef_ok = Coef_We && (Coef_Sel <= 3'd4)
                   && ({1'b0, Coef_Canal} < C_L)
                   && !((estado != REPOSO) && (Coef_Canal == canal_r));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            estado             <= REPOSO;
            k                  <= '0;
            x_r                <= '0;
            canal_r            <= '0;
            bypass_r           <= 1'b0;
            acc                <= '0;
            Yk                 <= '0;
            Canal_Yk           <= '0;
            Bandera_Listo      <= 1'b0;
            Ocupado            <= 1'b0;
            Bandera_Saturacion <= 1'b0;
            Bandera_Perdida    <= 1'b0;
            for (int i = 0; i < C; i++) begin
                hx1[i]     <= '0;
                hx2[i]     <= '0;
                hy1[i]     <= '0;
                hy2[i]     <= '0;
                coef[i][0] <= UNO;
                for (int j = 1; j < 5; j++) coef[i][j] <= '0;
            end
        end else begin
            Bandera_Listo   <= 1'b0;
            Bandera_Perdida <= 1'b0;
            if (coef_ok) coef[Coef_Canal][Coef_Sel] <= Coef_Dato;
            unique case (estado)
                REPOSO: begin
                    if (Bandera_ADC) begin
                        if ({1'b0, Canal} < C_L) begin
                            x_r      <= Uk;
                            canal_r  <= Canal;
                            bypass_r <= Bypass;
                            acc      <= '0;
                            k        <= '0;
                            estado   <= MAC;
                        end else begin
                            Bandera_Perdida <= 1'b1;
                        end
                    end
                end
                MAC: begin
                    Ocupado         <= 1'b1;
                    Bandera_Perdida <= Bandera_ADC;
                    acc             <= acc_nxt;
                    if (k == 3'd4) estado <= REDONDEO;
                    else           k      <= k + 3'd1;
                end
                REDONDEO: begin
                    Bandera_Perdida    <= Bandera_ADC;
                    Yk                 <= res_val;
                    Canal_Yk           <= canal_r;
                    Bandera_Saturacion <= res_sat;
                    Bandera_Listo      <= 1'b1;
                    Ocupado            <= 1'b0;
                    hx2[canal_r]       <= hx1[canal_r];
                    hx1[canal_r]       <= x_r;
                    hy2[canal_r]       <= hy1[canal_r];
                    hy1[canal_r]       <= res_val;
                    estado             <= REPOSO;
                end
                default: estado <= REPOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_filtro_iir_multicanal.sv
// Directed self-checking bench for filtro_iir_multicanal.
// Drives and samples on the falling edge; expected values are hand-computed.
module tb_filtro_iir_multicanal;

    localparam int N  = 25;
    localparam int F  = 15;
    localparam int C  = 2;
    localparam int CW = 1;

    logic                Clk = 1'b0;
    logic                Reset_n;
    logic signed [N-1:0] Uk;
    logic [CW-1:0]       Canal;
    logic                Bandera_ADC;
    logic                Bypass;
    logic                Coef_We;
    logic [2:0]          Coef_Sel;
    logic [CW-1:0]       Coef_Canal;
    logic signed [N-1:0] Coef_Dato;
    logic signed [N-1:0] Yk;
    logic [CW-1:0]       Canal_Yk;
    logic                Bandera_Listo;
    logic                Ocupado;
    logic                Bandera_Saturacion;
    logic                Bandera_Perdida;

    int n_tests = 0;
    int n_fail  = 0;

    logic signed [N-1:0] y;
    logic                s;
    logic [CW-1:0]       c;
    int                  lat;
    int                  ocup;
    int                  perd;
    logic                seen;

    always #5 Clk = ~Clk;

    filtro_iir_multicanal #(.N(N), .F(F), .C(C), .CW(CW)) dut (
        .Clk                (Clk),
        .Reset_n            (Reset_n),
        .Uk                 (Uk),
        .Canal              (Canal),
        .Bandera_ADC        (Bandera_ADC),
        .Bypass             (Bypass),
        .Coef_We            (Coef_We),
        .Coef_Sel           (Coef_Sel),
        .Coef_Canal         (Coef_Canal),
        .Coef_Dato          (Coef_Dato),
        .Yk                 (Yk),
        .Canal_Yk           (Canal_Yk),
        .Bandera_Listo      (Bandera_Listo),
        .Ocupado            (Ocupado),
        .Bandera_Saturacion (Bandera_Saturacion),
        .Bandera_Perdida    (Bandera_Perdida)
    );

    task automatic chk(input string tag,
                       input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic rst();
        @(negedge Clk);
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic coef_wr(input int ch, input int sel, input int val);
        @(negedge Clk);
        Coef_We    = 1'b1;
        Coef_Canal = CW'(ch);
        Coef_Sel   = 3'(sel);
        Coef_Dato  = N'(val);
        @(negedge Clk);
        Coef_We    = 1'b0;
    endtask

    // Sends one sample and waits (bounded) for its result
    task automatic muestra(input int ch, input int u, input logic byp,
                           output logic signed [N-1:0] yo,
                           output logic so,
                           output logic [CW-1:0] co,
                           output int lo,
                           output int oo);
        @(negedge Clk);
        Uk          = N'(u);
        Canal       = CW'(ch);
        Bypass      = byp;
        Bandera_ADC = 1'b1;
        @(negedge Clk);
        Bandera_ADC = 1'b0;
        lo = 0;
        oo = 0;
        while (!Bandera_Listo && lo < 20) begin
            @(negedge Clk);
            lo++;
            oo += int'(Ocupado);
        end
        chk("listo_seen", Bandera_Listo, 1);
        yo = Yk;
        so = Bandera_Saturacion;
        co = Canal_Yk;
    endtask

    initial begin
        int iir_exp [4];
        iir_exp = '{32768, 16384, 8192, 4096};

        Reset_n     = 1'b0;
        Uk          = '0;
        Canal       = '0;
        Bandera_ADC = 1'b0;
        Bypass      = 1'b0;
        Coef_We     = 1'b0;
        Coef_Sel    = '0;
        Coef_Canal  = '0;
        Coef_Dato   = '0;

        #12;
        chk("rst_yk",    Yk, 0);
        chk("rst_ch",    Canal_Yk, 0);
        chk("rst_listo", Bandera_Listo, 0);
        chk("rst_ocup",  Ocupado, 0);
        chk("rst_sat",   Bandera_Saturacion, 0);
        chk("rst_perd",  Bandera_Perdida, 0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Identity after reset
        muestra(0, 1000, 1'b0, y, s, c, lat, ocup);
        chk("ident_y",    y, 1000);
        chk("ident_ch",   c, 0);
        chk("ident_lat",  lat, 6);
        chk("ident_ocup", ocup, 5);
        @(negedge Clk);
        chk("listo_1cyc", Bandera_Listo, 0);
        chk("hold_y",     Yk, 1000);

        // FIR on ch0
        rst();
        coef_wr(0, 0, 16384);
        coef_wr(0, 1, 16384);
        muestra(0, 32768, 1'b0, y, s, c, lat, ocup);
        chk("fir_y0", y, 16384);
        chk("fir_s0", s, 0);
        muestra(0, 0, 1'b0, y, s, c, lat, ocup);
        chk("fir_y1", y, 16384);
        muestra(0, 0, 1'b0, y, s, c, lat, ocup);
        chk("fir_y2", y, 0);

        // IIR on ch1
        coef_wr(1, 0, 32768);
        coef_wr(1, 3, -16384);
        for (int i = 0; i < 4; i++) begin
            muestra(1, (i == 0) ? 32768 : 0, 1'b0, y, s, c, lat, ocup);
            chk("iir_y", y, iir_exp[i]);
            chk("iir_ch", c, 1);
        end
        muestra(0, 0, 1'b0, y, s, c, lat, ocup);
        chk("iso_y",  y, 0);
        chk("iso_ch", c, 0);

        // Saturation and bypass
        coef_wr(0, 0, 65536);
        muestra(0, 16777215, 1'b0, y, s, c, lat, ocup);
        chk("sat_pos_y", y, 16777215);
        chk("sat_pos_f", s, 1);
        muestra(0, -16777216, 1'b0, y, s, c, lat, ocup);
        chk("sat_neg_y", y, -16777216);
        chk("sat_neg_f", s, 1);
        muestra(0, 16777215, 1'b1, y, s, c, lat, ocup);
        chk("byp_y", y, 16777215);
        chk("byp_f", s, 0);

        // Reset in the middle of a computation
        @(negedge Clk);
        Uk          = N'(700);
        Canal       = '0;
        Bypass      = 1'b0;
        Bandera_ADC = 1'b1;
        @(negedge Clk);
        Bandera_ADC = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk("mid_ocup_pre", Ocupado, 1);
        @(posedge Clk);
        #1 Reset_n = 1'b0;
        #1;
        chk("mid_listo", Bandera_Listo, 0);
        chk("mid_yk",    Yk, 0);
        chk("mid_ocup",  Ocupado, 0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge Clk);
            seen = seen | Bandera_Listo;
        end
        chk("mid_nolisto", seen, 0);
        Reset_n = 1'b1;
        muestra(0, 500, 1'b0, y, s, c, lat, ocup);
        chk("post_rst_y", y, 500);

        // Dropped sample and coefficient write protection
        rst();
        perd = 0;
        @(negedge Clk);
        Uk          = N'(1234);
        Canal       = '0;
        Bypass      = 1'b0;
        Bandera_ADC = 1'b1;
        @(negedge Clk);
        Bandera_ADC = 1'b0;
        perd += int'(Bandera_Perdida);
        Coef_We    = 1'b1;
        Coef_Canal = '0;
        Coef_Sel   = 3'd0;
        Coef_Dato  = '0;
        @(negedge Clk);
        Coef_We = 1'b0;
        perd += int'(Bandera_Perdida);
        @(negedge Clk);
        perd += int'(Bandera_Perdida);
        Uk          = N'(999);
        Bandera_ADC = 1'b1;
        @(negedge Clk);
        Bandera_ADC = 1'b0;
        chk("perd_pulse", Bandera_Perdida, 1);
        perd += int'(Bandera_Perdida);
        Coef_We    = 1'b1;
        Coef_Canal = CW'(1);
        Coef_Sel   = 3'd0;
        Coef_Dato  = N'(16384);
        @(negedge Clk);
        Coef_We = 1'b0;
        perd += int'(Bandera_Perdida);
        lat = 4;
        while (!Bandera_Listo && lat < 20) begin
            @(negedge Clk);
            lat++;
            perd += int'(Bandera_Perdida);
        end
        chk("lost_listo", Bandera_Listo, 1);
        chk("lost_lat",   lat, 6);
        chk("lost_y",     Yk, 1234);
        chk("lost_once",  perd, 1);
        muestra(0, 200, 1'b0, y, s, c, lat, ocup);
        chk("prot_ch0", y, 200);
        muestra(1, 200, 1'b0, y, s, c, lat, ocup);
        chk("wr_ch1", y, 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
